// File: rtl/mem_config_pkg.sv
// Purpose: Shared memory geometry for the edge-detection image buffers.
// Contents:
//   ADDR_WIDTH - pixel address width of the input image memory
//   DATA_WIDTH - pixel width of the input image memory
package mem_config_pkg;

  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned DATA_WIDTH = 8;

endpackage

// File: rtl/sobel_config_pkg.sv
// Purpose: Frame controller configuration for the Sobel edge engine.
// Contents:
//   frame_state_e          - frame sequencing FSM states
//   DRAIN_CYCLES_DEF       - default post-finish drain length
//   TIMEOUT_CYCLES_DEF     - default run-phase watchdog limit
package sobel_config_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KICK  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } frame_state_e;

  localparam int unsigned DRAIN_CYCLES_DEF   = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 65535;

endpackage

// File: rtl/edge_frame_ctrl.sv
// Purpose: Frame sequencer for the Sobel edge engine. The host loads the
//   input image while the controller is idle, then the controller kicks the
//   engine, waits for its finish flag, drains trailing writes and reports a
//   completed frame. The input image memory port is shared: host writes in
//   IDLE, engine reads in every other state.
// Configuration:
//   EDGE_CTRL_TIMEOUT_EN - when defined, a run-phase watchdog forces the
//   frame to complete after TIMEOUT_CYCLES and raises a sticky timeout_o.
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   host_valid_i/addr/data host pixel write request
//   host_ready_o          host write accepted this cycle
//   host_load_done_i      frame loaded, start processing
//   sob_start_o           one-cycle start pulse to the engine
//   sob_finish_i          engine finished flag
//   sob_rd_addr_i         engine input-pixel read address
//   imem_addr_o/we_o/wdata_o  input image memory port
//   busy_o                frame in progress
//   frame_done_o          one-cycle frame-complete pulse
//   frame_cnt_o           completed-frame count (wraps)
//   timeout_o             sticky watchdog error
module edge_frame_ctrl
  import mem_config_pkg::*;
  import sobel_config_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES   = DRAIN_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  host_valid_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_data_i,
  output logic                  host_ready_o,
  input  logic                  host_load_done_i,
  output logic                  sob_start_o,
  input  logic                  sob_finish_i,
  input  logic [ADDR_WIDTH-1:0] sob_rd_addr_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic                  imem_we_o,
  output logic [DATA_WIDTH-1:0] imem_wdata_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [7:0]            frame_cnt_o,
  output logic                  timeout_o
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  frame_state_e       r_state;
  logic               r_sob_start;
  logic               r_frame_done;
  logic [7:0]         r_frame_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               w_idle;

`ifdef EDGE_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0]    r_wd_cnt;
  logic               r_timeout;
`else
  // Watchdog is compiled out; the limit parameter is kept for a uniform
  // parameter list across both builds.
  logic               w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_sob_start  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 8'd0;
      r_drain_cnt  <= '0;
`ifdef EDGE_CTRL_TIMEOUT_EN
      r_wd_cnt     <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      // Both pulses are single-cycle; only the transition into KICK/DONE raises them.
      r_sob_start  <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (host_load_done_i) begin
            r_state     <= ST_KICK;
            r_sob_start <= 1'b1;
`ifdef EDGE_CTRL_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
          end
        end
        ST_KICK: begin
          r_state <= ST_RUN;
`ifdef EDGE_CTRL_TIMEOUT_EN
          r_wd_cnt <= '0;
`endif
        end
        ST_RUN: begin
          if (sob_finish_i) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
          end
`ifdef EDGE_CTRL_TIMEOUT_EN
          else if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            // Forced completion still counts as a frame so the host sees an end.
            r_state      <= ST_DONE;
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 8'd1;
            r_timeout    <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`endif
        end
        ST_DRAIN: begin
          // Drain window lets the engine flush its trailing border-pixel writes.
          if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            r_state      <= ST_DONE;
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 8'd1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_idle = (r_state == ST_IDLE);

  // Memory port mux: host owns the port only while idle; the engine address
  // passes straight through otherwise so no read latency is added.
  assign host_ready_o = w_idle;
  assign imem_we_o    = w_idle & host_valid_i;
  assign imem_addr_o  = w_idle ? host_addr_i : sob_rd_addr_i;
  assign imem_wdata_o = w_idle ? host_data_i : '0;

  assign busy_o       = ~w_idle;
  assign sob_start_o  = r_sob_start;
  assign frame_done_o = r_frame_done;
  assign frame_cnt_o  = r_frame_cnt;

`ifdef EDGE_CTRL_TIMEOUT_EN
  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
